// File: rtl/fft_stream_sched_pkg.sv
// Shared types and helpers for the streaming FFT scheduler.
// Provides the scheduler state encoding, a log2 helper and a bit-reversal function.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAD   = 2'd2,
    FLUSH = 2'd3
  } sched_state_t;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  // Reverses the low w bits of v; bits at and above w are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    logic [4:0]  j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) begin
        j    = 5'(w - 1 - i);
        r[i] = v[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stream_sched_lat_tracker.sv
// Pipeline latency tracker: counts ce cycles up to the datapath latency,
// tracks frames in flight and produces the registered output-valid flag.
module fft_lat_tracker #(
  parameter int FFT_SIZE     = 16,
  parameter int PIPE_LATENCY = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce_i,
  input  logic sof_i,
  input  logic eop_i,
  input  logic clr_i,
  output logic m_valid_o,
  output logic drain_done_o
);

  localparam int LW = $clog2(PIPE_LATENCY + 1);
  localparam int OW = $clog2(PIPE_LATENCY / FFT_SIZE + 3);

  logic [LW-1:0] lat_q, lat_d;
  logic [OW-1:0] outst_q, outst_d;
  logic          m_valid_q, m_valid_d;
  logic          lat_full;

  always_comb begin
    lat_full = (lat_q == LW'(PIPE_LATENCY));
    lat_d    = lat_q;
    if (clr_i) begin
      lat_d = '0;
    end else if (ce_i && !lat_full) begin
      lat_d = lat_q + 1'b1;
    end
    outst_d = outst_q;
    if (sof_i && !eop_i) begin
      outst_d = outst_q + 1'b1;
    end else if (!sof_i && eop_i) begin
      outst_d = outst_q - 1'b1;
    end
    // Post-update count, so the ce cycle carrying the final eop reports nothing further.
    m_valid_d    = ce_i & lat_full & (outst_d != '0);
    drain_done_o = eop_i & (outst_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q     <= '0;
      outst_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      lat_q     <= lat_d;
      outst_q   <= outst_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_valid_o = m_valid_q;

endmodule

// File: rtl/fft_stream_sched.sv
// Stream scheduler for the single-path streaming FFT: input handshake, zero-padding,
// pipeline flush and output tagging. Optional FFT_STREAM_SCHED_STATS_EN adds frame_cnt/pad_seen.
module fft_stream_sched
  import fft_pkg::*;
#(
  parameter  int FFT_SIZE     = 16,
  parameter  int PIPE_LATENCY = 20,
  localparam int LOG2N        = log2n(FFT_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             fft_ce,
  output logic             fft_pad,
  output logic             fft_sof,
  output logic             m_valid,
  output logic             m_sop,
  output logic             m_eop,
  output logic [LOG2N-1:0] m_bin
`ifdef FFT_STREAM_SCHED_STATS_EN
  ,
  output logic [31:0]      frame_cnt,
  output logic             pad_seen
`endif
);

  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(FFT_SIZE - 1);

  sched_state_t     state_q, state_d;
  logic [LOG2N-1:0] in_idx_q, out_idx_q;
  logic             accept, padding, drain_done, to_idle;

  assign s_ready = (state_q == IDLE) || (state_q == RUN);
  assign padding = (state_q == PAD) || (state_q == FLUSH);
  assign accept  = s_valid & s_ready;
  assign fft_ce  = accept | padding;
  assign fft_pad = padding;
  // Flush cycles wrap in_idx but never start a real frame.
  assign fft_sof = fft_ce & (in_idx_q == '0) & (state_q != FLUSH);

  assign m_sop = m_valid & (out_idx_q == '0);
  assign m_eop = m_valid & (out_idx_q == IDX_LAST);
  assign m_bin = LOG2N'(bitrev(32'(out_idx_q), LOG2N));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (s_last) state_d = (in_idx_q == IDX_LAST) ? FLUSH : PAD;
          else        state_d = RUN;
        end
      end
      PAD:     if (in_idx_q == IDX_LAST) state_d = FLUSH;
      FLUSH:   if (drain_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    to_idle = (state_q == FLUSH) && drain_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_idx_q  <= '0;
      out_idx_q <= '0;
    end else begin
      state_q <= state_d;
      // Realign the input frame counter so the next stream starts at sample 0.
      if (to_idle)     in_idx_q <= '0;
      else if (fft_ce) in_idx_q <= in_idx_q + 1'b1;
      if (m_valid) out_idx_q <= out_idx_q + 1'b1;
    end
  end

  fft_lat_tracker #(
    .FFT_SIZE    (FFT_SIZE),
    .PIPE_LATENCY(PIPE_LATENCY)
  ) u_lat (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce_i        (fft_ce),
    .sof_i       (fft_sof),
    .eop_i       (m_eop),
    .clr_i       (to_idle),
    .m_valid_o   (m_valid),
    .drain_done_o(drain_done)
  );

`ifdef FFT_STREAM_SCHED_STATS_EN
  logic [31:0] frame_cnt_q;
  logic        pad_seen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      pad_seen_q  <= 1'b0;
    end else begin
      if (m_eop) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (state_d == PAD && state_q != PAD) pad_seen_q <= 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign pad_seen  = pad_seen_q;
`endif

endmodule
